// File: rtl/rbcp_reg_pkg.sv
// Shared constants and types for the SiTCP RBCP register responder.
package rbcp_reg_pkg;

    localparam int unsigned OFS_ID0      = 0;
    localparam int unsigned OFS_ID1      = 1;
    localparam int unsigned OFS_ID2      = 2;
    localparam int unsigned OFS_ID3      = 3;
    localparam int unsigned OFS_CTRL     = 4;
    localparam int unsigned OFS_PULSE    = 5;
    localparam int unsigned OFS_STAT_H   = 6;
    localparam int unsigned OFS_STAT_L   = 7;
    localparam int unsigned OFS_GP_FIRST = 8;

    localparam logic [31:0] DEFAULT_ID = 32'h5346_4350;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } rbcp_state_t;

    // Request captured from the bus when a strobe is accepted.
    typedef struct packed {
        logic [7:0] wd;
        logic       is_wr;
        logic       is_rd;
    } rbcp_req_t;

endpackage

// File: rtl/rbcp_reg_slave.sv
// RBCP register slave: decodes SiTCP byte strobes into a small slow-control
// register file and answers each accepted strobe with a fixed 2-cycle ACK.
module rbcp_reg_slave
    import rbcp_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned REG_NUM   = 32,
    parameter logic [31:0] ID_VALUE  = DEFAULT_ID
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     RBCP_ACT,
    input  logic [31:0]              RBCP_ADDR,
    input  logic                     RBCP_WE,
    input  logic [7:0]               RBCP_WD,
    input  logic                     RBCP_RE,
    output logic                     RBCP_ACK,
    output logic [7:0]               RBCP_RD,
    input  logic [15:0]              STATUS_IN,
    output logic [7:0]               CTRL_OUT,
    output logic [7:0]               PULSE_OUT,
    output logic [8*(REG_NUM-8)-1:0] REG_OUT
);

    localparam int unsigned AW     = $clog2(REG_NUM);
    localparam int unsigned GP_NUM = REG_NUM - OFS_GP_FIRST;

    rbcp_state_t state_q, state_d;
    rbcp_req_t   req_q, req_d;
    logic [AW-1:0] ofs_q, ofs_d;
    logic        ack_q, ack_d;
    logic [7:0]  rd_q, rd_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  pulse_q, pulse_d;
    logic        perr_q, perr_d;
    logic [15:0] status_q;
    logic [7:0]  gp_q [GP_NUM];
    logic        gp_we_c;
    logic        hit_c;
    logic [7:0]  rd_val_c;

    assign hit_c = RBCP_ACT && (RBCP_WE || RBCP_RE)
                   && (RBCP_ADDR[31:AW] == BASE_ADDR[31:AW]);

    // Read mux; a write in the same transaction is forwarded to the read.
    always_comb begin
        rd_val_c = 8'h00;
        case (ofs_q)
            AW'(OFS_ID0):    rd_val_c = ID_VALUE[31:24];
            AW'(OFS_ID1):    rd_val_c = ID_VALUE[23:16];
            AW'(OFS_ID2):    rd_val_c = ID_VALUE[15:8];
            AW'(OFS_ID3):    rd_val_c = ID_VALUE[7:0];
            AW'(OFS_CTRL):   rd_val_c = req_q.is_wr ? req_q.wd : ctrl_q;
            AW'(OFS_PULSE):  rd_val_c = {7'b000_0000, perr_q};
            AW'(OFS_STAT_H): rd_val_c = status_q[15:8];
            AW'(OFS_STAT_L): rd_val_c = status_q[7:0];
            default: begin
                for (int i = 0; i < int'(GP_NUM); i++) begin
                    if (ofs_q == AW'(i + int'(OFS_GP_FIRST))) begin
                        rd_val_c = req_q.is_wr ? req_q.wd : gp_q[i];
                    end
                end
            end
        endcase
    end

    // Next-state and next-register values.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ofs_d   = ofs_q;
        ack_d   = 1'b0;
        rd_d    = 8'h00;
        ctrl_d  = ctrl_q;
        pulse_d = 8'h00;
        perr_d  = perr_q;
        gp_we_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit_c) begin
                    ofs_d       = RBCP_ADDR[AW-1:0];
                    req_d.wd    = RBCP_WD;
                    req_d.is_wr = RBCP_WE;
                    req_d.is_rd = RBCP_RE;
                    if (RBCP_WE && RBCP_RE) begin
                        perr_d = 1'b1;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (hit_c) begin
                    perr_d = 1'b1;
                end
                if (req_q.is_wr) begin
                    if (ofs_q == AW'(OFS_CTRL)) begin
                        ctrl_d = req_q.wd;
                    end
                    if (ofs_q == AW'(OFS_PULSE)) begin
                        pulse_d = req_q.wd;
                    end
                    if (ofs_q >= AW'(OFS_GP_FIRST)) begin
                        gp_we_c = 1'b1;
                    end
                end
                // A dropped transaction still commits its write but is not acknowledged.
                if (RBCP_ACT) begin
                    ack_d   = 1'b1;
                    rd_d    = req_q.is_rd ? rd_val_c : 8'h00;
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (hit_c) begin
                    perr_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register file.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            req_q    <= '0;
            ofs_q    <= '0;
            ack_q    <= 1'b0;
            rd_q     <= 8'h00;
            ctrl_q   <= 8'h00;
            pulse_q  <= 8'h00;
            perr_q   <= 1'b0;
            status_q <= 16'h0000;
            for (int i = 0; i < int'(GP_NUM); i++) begin
                gp_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            ofs_q    <= ofs_d;
            ack_q    <= ack_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            pulse_q  <= pulse_d;
            perr_q   <= perr_d;
            status_q <= STATUS_IN;
            for (int i = 0; i < int'(GP_NUM); i++) begin
                if (gp_we_c && (ofs_q == AW'(i + int'(OFS_GP_FIRST)))) begin
                    gp_q[i] <= req_q.wd;
                end
            end
        end
    end

    assign RBCP_ACK  = ack_q;
    assign RBCP_RD   = rd_q;
    assign CTRL_OUT  = ctrl_q;
    assign PULSE_OUT = pulse_q;

    for (genvar g = 0; g < int'(GP_NUM); g++) begin : g_reg_out
        assign REG_OUT[8*g +: 8] = gp_q[g];
    end

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Randomized self-checking bench for rbcp_reg_slave against a register-map model.
module tb_rbcp_reg_slave;

    localparam int unsigned REG_NUM = 32;
    localparam int unsigned GP_NUM  = REG_NUM - 8;

    logic                     CLK = 1'b0;
    logic                     RSTn;
    logic                     RBCP_ACT;
    logic [31:0]              RBCP_ADDR;
    logic                     RBCP_WE;
    logic [7:0]               RBCP_WD;
    logic                     RBCP_RE;
    logic                     RBCP_ACK;
    logic [7:0]               RBCP_RD;
    logic [15:0]              STATUS_IN;
    logic [7:0]               CTRL_OUT;
    logic [7:0]               PULSE_OUT;
    logic [8*(REG_NUM-8)-1:0] REG_OUT;

    rbcp_reg_slave #(
        .BASE_ADDR (32'h0000_0000),
        .REG_NUM   (REG_NUM),
        .ID_VALUE  (32'h5346_4350)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .RBCP_ACT  (RBCP_ACT),
        .RBCP_ADDR (RBCP_ADDR),
        .RBCP_WE   (RBCP_WE),
        .RBCP_WD   (RBCP_WD),
        .RBCP_RE   (RBCP_RE),
        .RBCP_ACK  (RBCP_ACK),
        .RBCP_RD   (RBCP_RD),
        .STATUS_IN (STATUS_IN),
        .CTRL_OUT  (CTRL_OUT),
        .PULSE_OUT (PULSE_OUT),
        .REG_OUT   (REG_OUT)
    );

    always #4 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference register map
    logic [31:0] id_m = 32'h5346_4350;
    logic [7:0]  ctrl_m;
    logic        perr_m;
    logic [7:0]  gp_m [GP_NUM];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        ctrl_m = 8'h00;
        perr_m = 1'b0;
        for (int i = 0; i < int'(GP_NUM); i++) gp_m[i] = 8'h00;
    endtask

    function automatic logic [8*(REG_NUM-8)-1:0] model_reg_out();
        logic [8*(REG_NUM-8)-1:0] v;
        for (int i = 0; i < int'(GP_NUM); i++) v[8*i +: 8] = gp_m[i];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input int ofs, input logic [15:0] st);
        logic [31:0] sh;
        if (ofs < 4) begin
            sh = id_m >> (8 * (3 - ofs));
            return sh[7:0];
        end
        if (ofs == 4) return ctrl_m;
        if (ofs == 5) return {7'b0, perr_m};
        if (ofs == 6) return st[15:8];
        if (ofs == 7) return st[7:0];
        return gp_m[ofs-8];
    endfunction

    task automatic model_write(input int ofs, input logic [7:0] wd, output logic [7:0] pulse);
        pulse = 8'h00;
        if (ofs == 4) ctrl_m = wd;
        else if (ofs == 5) pulse = wd;
        else if (ofs >= 8) gp_m[ofs-8] = wd;
    endtask

    // One strobe at cycle n; checks cycles n+1, n+2, n+3.
    task automatic txn(input logic [31:0] addr, input logic we, input logic re,
                       input logic [7:0] wd, input logic [15:0] st, input logic act_exec);
        logic       hit;
        int         ofs;
        logic [7:0] exp_rd;
        logic [7:0] exp_pulse;
        logic       exp_ack;
        hit = (addr[31:5] == 27'd0);
        ofs = int'(addr[4:0]);
        RBCP_ACT  = 1'b1;
        RBCP_ADDR = addr;
        RBCP_WE   = we;
        RBCP_RE   = re;
        RBCP_WD   = wd;
        STATUS_IN = st;
        step();
        RBCP_WE   = 1'b0;
        RBCP_RE   = 1'b0;
        STATUS_IN = 16'($urandom);
        if (!act_exec) RBCP_ACT = 1'b0;
        check("ack_n1", RBCP_ACK, 1'b0);
        exp_pulse = 8'h00;
        exp_rd    = 8'h00;
        if (hit) begin
            if (we && re) perr_m = 1'b1;
            if (we) model_write(ofs, wd, exp_pulse);
            if (re) exp_rd = model_read(ofs, st);
        end
        exp_ack = hit && act_exec;
        step();
        check("ack_n2", RBCP_ACK, exp_ack);
        if (!exp_ack) check("rd_idle", RBCP_RD, 8'h00);
        else if (re) check("rd_data", RBCP_RD, exp_rd);
        check("ctrl", CTRL_OUT, ctrl_m);
        check("pulse_n2", PULSE_OUT, exp_pulse);
        check("reg_out", REG_OUT, model_reg_out());
        RBCP_ACT = 1'b1;
        step();
        check("ack_n3", RBCP_ACK, 1'b0);
        check("pulse_n3", PULSE_OUT, 8'h00);
    endtask

    initial begin
        int acks;
        RSTn = 1'b0; RBCP_ACT = 1'b0; RBCP_ADDR = '0; RBCP_WE = 1'b0;
        RBCP_RE = 1'b0; RBCP_WD = '0; STATUS_IN = '0;
        model_reset();
        repeat (3) step();
        check("rst_ack", RBCP_ACK, 1'b0);
        check("rst_rd", RBCP_RD, 8'h00);
        check("rst_ctrl", CTRL_OUT, 8'h00);
        check("rst_pulse", PULSE_OUT, 8'h00);
        check("rst_reg", REG_OUT, '0);
        RSTn = 1'b1;
        RBCP_ACT = 1'b1;
        step();

        // ID bytes, control, pulse, top GP register, status
        for (int k = 0; k < 4; k++) txn(32'(k), 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1);
        txn(32'h04, 1'b1, 1'b0, 8'hA5, 16'h0, 1'b1);
        txn(32'h04, 1'b0, 1'b1, 8'h00, 16'h0, 1'b1);
        txn(32'h05, 1'b1, 1'b0, 8'h81, 16'h0, 1'b1);
        txn(32'h05, 1'b0, 1'b1, 8'h00, 16'h0, 1'b1);
        txn(32'h1F, 1'b1, 1'b0, 8'h3C, 16'h0, 1'b1);
        check("reg_1f", REG_OUT[191:184], 8'h3C);
        txn(32'h00, 1'b1, 1'b0, 8'hFF, 16'h0, 1'b1);
        txn(32'h06, 1'b0, 1'b1, 8'h00, 16'hBEEF, 1'b1);
        txn(32'h07, 1'b0, 1'b1, 8'h00, 16'hBEEF, 1'b1);

        // Miss: no ACK within 16 cycles and no state change
        RBCP_ADDR = 32'h20; RBCP_WE = 1'b1; RBCP_WD = 8'h99;
        step();
        RBCP_WE = 1'b0;
        acks = 0;
        for (int c = 0; c < 16; c++) begin
            if (RBCP_ACK) acks++;
            step();
        end
        check("miss_acks", 32'(acks), 32'd0);
        check("miss_ctrl", CTRL_OUT, ctrl_m);
        check("miss_reg", REG_OUT, model_reg_out());

        // Second strobe at n+1 is dropped and flags a protocol error
        RBCP_ADDR = 32'h04; RBCP_RE = 1'b1;
        step();
        RBCP_RE = 1'b0; RBCP_WE = 1'b1; RBCP_WD = 8'hEE;
        check("dbl_ack_n1", RBCP_ACK, 1'b0);
        step();
        RBCP_WE = 1'b0;
        check("dbl_ack_n2", RBCP_ACK, 1'b1);
        check("dbl_rd", RBCP_RD, ctrl_m);
        perr_m = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (RBCP_ACK) acks++;
        end
        check("dbl_extra_acks", 32'(acks), 32'd0);
        check("dbl_ctrl", CTRL_OUT, ctrl_m);
        txn(32'h05, 1'b0, 1'b1, 8'h00, 16'h0, 1'b1);

        // Reset at n+1 aborts the transaction
        RBCP_ADDR = 32'h04; RBCP_WE = 1'b1; RBCP_WD = 8'h77;
        step();
        RBCP_WE = 1'b0; RSTn = 1'b0;
        step();
        model_reset();
        check("mrst_ack", RBCP_ACK, 1'b0);
        check("mrst_rd", RBCP_RD, 8'h00);
        check("mrst_ctrl", CTRL_OUT, 8'h00);
        check("mrst_pulse", PULSE_OUT, 8'h00);
        check("mrst_reg", REG_OUT, '0);
        RSTn = 1'b1;
        step();
        check("mrst_ack2", RBCP_ACK, 1'b0);
        txn(32'h05, 1'b0, 1'b1, 8'h00, 16'h0, 1'b1);

        // WE and RE together: write wins, one ACK, error flag set
        txn(32'h04, 1'b1, 1'b1, 8'h11, 16'h0, 1'b1);
        check("both_ctrl", CTRL_OUT, 8'h11);
        txn(32'h05, 1'b0, 1'b1, 8'h00, 16'h0, 1'b1);

        // ACT dropped during EXEC: write commits, no ACK
        txn(32'h09, 1'b1, 1'b0, 8'h5A, 16'h0, 1'b0);
        txn(32'h09, 1'b0, 1'b1, 8'h00, 16'h0, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            logic        w;
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0020;
            else a = 32'($urandom_range(0, REG_NUM - 1));
            w = 1'($urandom_range(0, 1));
            txn(a, w, !w, 8'($urandom), 16'($urandom), ($urandom_range(0, 15) != 0));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
